id_ex_operand_latch: RTL

//  ID-stage operand forwarding muxes plus the ID/EX pipeline register of the MIPS-Lite DLX.

---
 rtl/id_ex_operand_latch_pkg.sv | 17 +
 rtl/id_ex_operand_latch_operand_fwd_mux.sv | 30 +++
 rtl/id_ex_operand_latch.sv | 107 ++++++++++
 3 files changed

// File: rtl/id_ex_operand_latch_pkg.sv
// Shared DLX definitions for the ID/EX operand latch: bypass select
// codes and the default bubble instruction (sll r0,r0,0).
package id_ex_operand_latch_pkg;

  // Operand source codes driven by the ID bypass controller (RSsel/RTsel)
  typedef enum logic [2:0] {
    SEL_REG_FILE_PATH     = 3'd0,
    SEL_STAGE3_BYPASS     = 3'd1,
    SEL_STAGE4_BYPASS     = 3'd2,
    SEL_STAGE4LOAD_BYPASS = 3'd3,
    SEL_STAGE4JAL_BYPASS  = 3'd4
  } fwd_sel_e;

  // Bubble instruction: sll r0,r0,0 encodes as all zeros
  localparam logic [31:0] DLX_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/id_ex_operand_latch_operand_fwd_mux.sv
// Five-source operand forwarding mux keyed on a 3-bit bypass select.
// Unknown select codes fall back to the register file value.
module operand_fwd_mux
  import id_ex_operand_latch_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    sel,
  input  logic [DW-1:0] rf,
  input  logic [DW-1:0] alu_ex,
  input  logic [DW-1:0] alu_mem,
  input  logic [DW-1:0] lmd_mem,
  input  logic [DW-1:0] pc4_mem,
  output logic [DW-1:0] operand
);

  // Select the operand source; the JAL link value is the MEM PC+4 plus 4
  always_comb begin
    operand = rf;
    case (sel)
      SEL_REG_FILE_PATH:     operand = rf;
      SEL_STAGE3_BYPASS:     operand = alu_ex;
      SEL_STAGE4_BYPASS:     operand = alu_mem;
      SEL_STAGE4LOAD_BYPASS: operand = lmd_mem;
      SEL_STAGE4JAL_BYPASS:  operand = pc4_mem + DW'(4);
      default:               operand = rf;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_latch.sv
// ID-stage operand forwarding plus the ID/EX pipeline register.
// Loads a NOP bubble on flush or load-use stall, otherwise advances the
// ID instruction with its forwarded operands.
// Optional: define DLX_BUBBLE_CNT_EN to add the saturating bubble_cnt output.
module id_ex_operand_latch
  import id_ex_operand_latch_pkg::*;
#(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] NOP_WORD = DW'(DLX_NOP_WORD)
`ifdef DLX_BUBBLE_CNT_EN
  ,
  parameter int            CNT_W    = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    ir_id,
  input  logic [DW-1:0]    pc4_id,
  input  logic [DW-1:0]    rf_rs,
  input  logic [DW-1:0]    rf_rt,
  input  logic [DW-1:0]    alu_ex,
  input  logic [DW-1:0]    alu_mem,
  input  logic [DW-1:0]    lmd_mem,
  input  logic [DW-1:0]    pc4_mem,
  input  logic [2:0]       rs_sel,
  input  logic [2:0]       rt_sel,
  input  logic             stall,
  input  logic             flush,
  output logic [DW-1:0]    rs_fwd,
  output logic [DW-1:0]    rt_fwd,
  output logic             rs_eq_rt,
  output logic             id_hold,
  output logic [DW-1:0]    ir_ex,
  output logic [DW-1:0]    a_ex,
  output logic [DW-1:0]    b_ex,
  output logic [DW-1:0]    pc4_ex
`ifdef DLX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  logic load_bubble;

  operand_fwd_mux #(.DW(DW)) u_rs_mux (
    .sel     (rs_sel),
    .rf      (rf_rs),
    .alu_ex  (alu_ex),
    .alu_mem (alu_mem),
    .lmd_mem (lmd_mem),
    .pc4_mem (pc4_mem),
    .operand (rs_fwd)
  );

  operand_fwd_mux #(.DW(DW)) u_rt_mux (
    .sel     (rt_sel),
    .rf      (rf_rt),
    .alu_ex  (alu_ex),
    .alu_mem (alu_mem),
    .lmd_mem (lmd_mem),
    .pc4_mem (pc4_mem),
    .operand (rt_fwd)
  );

  // Branch compare, hold request and bubble decision (flush beats stall)
  always_comb begin
    rs_eq_rt    = (rs_fwd == rt_fwd);
    id_hold     = stall & ~flush;
    load_bubble = flush | stall;
  end

  // ID/EX boundary: bubble on flush or stall, otherwise advance the ID instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_ex  <= NOP_WORD;
      a_ex   <= '0;
      b_ex   <= '0;
      pc4_ex <= '0;
    end else if (load_bubble) begin
      ir_ex  <= NOP_WORD;
      a_ex   <= '0;
      b_ex   <= '0;
      pc4_ex <= '0;
    end else begin
      ir_ex  <= ir_id;
      a_ex   <= rs_fwd;
      b_ex   <= rt_fwd;
      pc4_ex <= pc4_id;
    end
  end

`ifdef DLX_BUBBLE_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Count inserted bubbles, sticking at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (load_bubble) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
`endif

endmodule
